cdb_rs: RTL and testbench



---
 rtl/cdb_rs_pkg.sv | 33 +++
 rtl/cdb_rs_if.sv | 49 ++++
 rtl/rs_pick_lowest.sv | 27 ++
 rtl/cdb_rs.sv | 186 ++++++++++++++++++
 tb/tb_cdb_rs.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_rs_pkg.sv
// rtl/cdb_rs_pkg.sv - shared widths, free-value constants and opcodes for the CDB reservation station
package cdb_rs_pkg;

  localparam int RS_ENTRIES = 8;
  localparam int RS_DATA_W  = 32;
  localparam int RS_TAG_W   = 4;
  localparam int RS_NAME_W  = 5;
  localparam int RS_OP_W    = 5;

  // Tag 0 is never a live ROB entry, so it marks an operand as already resolved.
  localparam logic [RS_TAG_W-1:0]  TAG_FREE  = '0;
  localparam logic [RS_DATA_W-1:0] DATA_FREE = '0;
  localparam logic [RS_NAME_W-1:0] NAME_FREE = '0;

  localparam logic WRT_ENABLE  = 1'b1;
  localparam logic WRT_DISABLE = 1'b0;

  typedef enum logic [RS_OP_W-1:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_AND = 5'd2,
    OP_OR  = 5'd3,
    OP_XOR = 5'd4,
    OP_SLL = 5'd5,
    OP_SRL = 5'd6
  } alu_op_e;

  // Occupancy counter must be able to hold the value ENTRIES itself.
  function automatic int cnt_width(input int entries);
    return $clog2(entries) + 1;
  endfunction

endpackage

// File: rtl/cdb_rs_if.sv
// rtl/cdb_rs_if.sv - dispatch, CDB snoop and issue signals of the reservation station
interface cdb_rs_if
  import cdb_rs_pkg::*;
#(
  parameter int DATA_W = RS_DATA_W,
  parameter int TAG_W  = RS_TAG_W,
  parameter int NAME_W = RS_NAME_W,
  parameter int OP_W   = RS_OP_W,
  parameter int CNT_W  = cnt_width(RS_ENTRIES)
);

  logic              disp_en;
  logic [OP_W-1:0]   disp_op;
  logic [TAG_W-1:0]  disp_tag1;
  logic [TAG_W-1:0]  disp_tag2;
  logic [DATA_W-1:0] disp_data1;
  logic [DATA_W-1:0] disp_data2;
  logic [TAG_W-1:0]  disp_dst_tag;
  logic [NAME_W-1:0] disp_dst_name;
  logic              rs_full;
  logic [CNT_W-1:0]  rs_count;

  logic              cdb_en;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              iss_valid;
  logic              iss_ready;
  logic [OP_W-1:0]   iss_op;
  logic [DATA_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_b;
  logic [TAG_W-1:0]  iss_tag;
  logic [NAME_W-1:0] iss_name;

  // Dispatch/CDB/ALU side.
  modport master (
    output disp_en, disp_op, disp_tag1, disp_tag2, disp_data1, disp_data2,
           disp_dst_tag, disp_dst_name, cdb_en, cdb_tag, cdb_data, iss_ready,
    input  rs_full, rs_count, iss_valid, iss_op, iss_a, iss_b, iss_tag, iss_name
  );

  // Reservation station side.
  modport slave (
    input  disp_en, disp_op, disp_tag1, disp_tag2, disp_data1, disp_data2,
           disp_dst_tag, disp_dst_name, cdb_en, cdb_tag, cdb_data, iss_ready,
    output rs_full, rs_count, iss_valid, iss_op, iss_a, iss_b, iss_tag, iss_name
  );

endinterface

// File: rtl/rs_pick_lowest.sv
// rtl/rs_pick_lowest.sv - lowest-index priority pick: isolates the lowest set bit and encodes its index
module rs_pick_lowest #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         hit,
  output logic [W-1:0] idx
);

  logic [N-1:0] onehot;

  // Two's-complement trick keeps only the lowest requesting bit.
  assign onehot = req & (~req + N'(1));
  assign hit    = |req;

  // Encode the single surviving bit into a binary index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        idx = idx | W'(i);
      end
    end
  end

endmodule

// File: rtl/cdb_rs.sv
// rtl/cdb_rs.sv - reservation station snooping the CDB and issuing ready ALU ops (optional RS_FLUSH_EN adds a synchronous flush input)
module cdb_rs
  import cdb_rs_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES,
  parameter int DATA_W  = RS_DATA_W,
  parameter int TAG_W   = RS_TAG_W,
  parameter int NAME_W  = RS_NAME_W,
  parameter int OP_W    = RS_OP_W
) (
  input logic     clk,
  input logic     rst,
`ifdef RS_FLUSH_EN
  input logic     flush,
`endif
  cdb_rs_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = cnt_width(ENTRIES);
  localparam logic [TAG_W-1:0]  TFREE = TAG_W'(TAG_FREE);
  localparam logic [DATA_W-1:0] DFREE = DATA_W'(DATA_FREE);
  localparam logic [NAME_W-1:0] NFREE = NAME_W'(NAME_FREE);

  logic [ENTRIES-1:0] valid;
  logic [OP_W-1:0]    op_q     [ENTRIES];
  logic [TAG_W-1:0]   tag1_q   [ENTRIES];
  logic [DATA_W-1:0]  data1_q  [ENTRIES];
  logic [TAG_W-1:0]   tag2_q   [ENTRIES];
  logic [DATA_W-1:0]  data2_q  [ENTRIES];
  logic [TAG_W-1:0]   dtag_q   [ENTRIES];
  logic [NAME_W-1:0]  dname_q  [ENTRIES];

  logic               iss_valid_q;
  logic [OP_W-1:0]    iss_op_q;
  logic [DATA_W-1:0]  iss_a_q;
  logic [DATA_W-1:0]  iss_b_q;
  logic [TAG_W-1:0]   iss_tag_q;
  logic [NAME_W-1:0]  iss_name_q;

  logic [CNT_W-1:0]   count_q;
  logic               full_q;
  logic [CNT_W-1:0]   count_nxt;

  logic [ENTRIES-1:0] free_vec;
  logic [ENTRIES-1:0] ready_vec;
  logic               free_hit;
  logic               rdy_hit;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   rdy_idx;

  logic               flush_now;
  logic               cdb_hit;
  logic               byp1;
  logic               byp2;
  logic               iss_take;
  logic               do_alloc;
  logic               do_issue;

`ifdef RS_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // Per-slot free and ready vectors from registered state only.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      free_vec[i]  = !valid[i];
      ready_vec[i] = valid[i] && (tag1_q[i] == TFREE) && (tag2_q[i] == TFREE);
    end
  end

  rs_pick_lowest #(.N(ENTRIES), .W(IDX_W)) u_pick_free (
    .req (free_vec),
    .hit (free_hit),
    .idx (free_idx)
  );

  rs_pick_lowest #(.N(ENTRIES), .W(IDX_W)) u_pick_ready (
    .req (ready_vec),
    .hit (rdy_hit),
    .idx (rdy_idx)
  );

  // A zero tag on the CDB carries no producer, so it never wakes anything.
  assign cdb_hit  = bus.cdb_en && (bus.cdb_tag != TFREE);
  assign byp1     = cdb_hit && (bus.disp_tag1 == bus.cdb_tag);
  assign byp2     = cdb_hit && (bus.disp_tag2 == bus.cdb_tag);
  assign iss_take = !iss_valid_q || bus.iss_ready;
  assign do_alloc = bus.disp_en && !full_q && free_hit && !flush_now;
  assign do_issue = iss_take && rdy_hit && !flush_now;
  assign count_nxt = count_q + CNT_W'(do_alloc) - CNT_W'(do_issue);

  // Slot array: CDB wakeup, issue invalidation and dispatch allocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]    <= '0;
        tag1_q[i]  <= TFREE;
        data1_q[i] <= DFREE;
        tag2_q[i]  <= TFREE;
        data2_q[i] <= DFREE;
        dtag_q[i]  <= TFREE;
        dname_q[i] <= NFREE;
      end
    end else if (flush_now) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (valid[i] && cdb_hit && (tag1_q[i] == bus.cdb_tag)) begin
          tag1_q[i]  <= TFREE;
          data1_q[i] <= bus.cdb_data;
        end
        if (valid[i] && cdb_hit && (tag2_q[i] == bus.cdb_tag)) begin
          tag2_q[i]  <= TFREE;
          data2_q[i] <= bus.cdb_data;
        end
      end
      if (do_issue) begin
        valid[rdy_idx] <= WRT_DISABLE;
      end
      // The allocated slot is invalid, so it never collides with wakeup or issue.
      if (do_alloc) begin
        valid[free_idx]   <= WRT_ENABLE;
        op_q[free_idx]    <= bus.disp_op;
        tag1_q[free_idx]  <= byp1 ? TFREE : bus.disp_tag1;
        data1_q[free_idx] <= byp1 ? bus.cdb_data : bus.disp_data1;
        tag2_q[free_idx]  <= byp2 ? TFREE : bus.disp_tag2;
        data2_q[free_idx] <= byp2 ? bus.cdb_data : bus.disp_data2;
        dtag_q[free_idx]  <= bus.disp_dst_tag;
        dname_q[free_idx] <= bus.disp_dst_name;
      end
    end
  end

  // Occupancy and full flag track the valid bits after each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (flush_now) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_W'(ENTRIES));
    end
  end

  // Issue register: reload whenever empty or accepted, hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_tag_q   <= '0;
      iss_name_q  <= '0;
    end else if (flush_now) begin
      iss_valid_q <= 1'b0;
    end else if (iss_take) begin
      iss_valid_q <= rdy_hit;
      if (rdy_hit) begin
        iss_op_q   <= op_q[rdy_idx];
        iss_a_q    <= data1_q[rdy_idx];
        iss_b_q    <= data2_q[rdy_idx];
        iss_tag_q  <= dtag_q[rdy_idx];
        iss_name_q <= dname_q[rdy_idx];
      end
    end
  end

  assign bus.rs_full   = full_q;
  assign bus.rs_count  = count_q;
  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_op    = iss_op_q;
  assign bus.iss_a     = iss_a_q;
  assign bus.iss_b     = iss_b_q;
  assign bus.iss_tag   = iss_tag_q;
  assign bus.iss_name  = iss_name_q;

endmodule

// File: tb/tb_cdb_rs.sv
// tb/tb_cdb_rs.sv - scoreboard bench for cdb_rs (flush checks under RS_FLUSH_EN)
module tb_cdb_rs;
  import cdb_rs_pkg::*;

  logic clk;
  logic rst;
`ifdef RS_FLUSH_EN
  logic flush;
`endif

  cdb_rs_if bus ();

  cdb_rs dut (
    .clk   (clk),
    .rst   (rst),
`ifdef RS_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  typedef logic [77:0] pkt_t;

  int   tests;
  int   fails;
  pkt_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pkt_t pack(input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] tag,
                                input logic [4:0] name);
    return {op, a, b, tag, name};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [4:0] op, input logic [3:0] t1, input logic [31:0] d1,
                          input logic [3:0] t2, input logic [31:0] d2,
                          input logic [3:0] dt, input logic [4:0] dn);
    bus.disp_en       = 1'b1;
    bus.disp_op       = op;
    bus.disp_tag1     = t1;
    bus.disp_data1    = d1;
    bus.disp_tag2     = t2;
    bus.disp_data2    = d2;
    bus.disp_dst_tag  = dt;
    bus.disp_dst_name = dn;
    step();
    bus.disp_en = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] d);
    bus.cdb_en   = 1'b1;
    bus.cdb_tag  = t;
    bus.cdb_data = d;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every accepted issue must match the oldest expected packet.
  always @(negedge clk) begin
    pkt_t e;
    if (!rst && bus.iss_valid && bus.iss_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: got tag %0h name %0h a %0h, required no issue",
                 bus.iss_tag, bus.iss_name, bus.iss_a);
      end else begin
        e = exp_q.pop_front();
        check("issue_pkt", pack(bus.iss_op, bus.iss_a, bus.iss_b, bus.iss_tag, bus.iss_name), e);
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
`ifdef RS_FLUSH_EN
    flush = 1'b0;
`endif
    bus.disp_en = 1'b0; bus.disp_op = '0; bus.disp_tag1 = '0; bus.disp_tag2 = '0;
    bus.disp_data1 = '0; bus.disp_data2 = '0; bus.disp_dst_tag = '0; bus.disp_dst_name = '0;
    bus.cdb_en = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.iss_ready = 1'b1;

    #3;
    check("rst_iss_valid", bus.iss_valid, 0);
    check("rst_count", bus.rs_count, 0);
    check("rst_full", bus.rs_full, 0);
    check("rst_iss_fields", {bus.iss_op, bus.iss_a, bus.iss_b, bus.iss_tag, bus.iss_name}, 0);
    step();
    rst = 1'b0;
    step();

    // Ready-operand dispatch issues one edge later.
    exp_q.push_back(pack(OP_ADD, 32'd5, 32'd7, 4'd1, 5'd3));
    dispatch(OP_ADD, 4'd0, 32'd5, 4'd0, 32'd7, 4'd1, 5'd3);
    check("t1_count_after_disp", bus.rs_count, 1);
    check("t1_no_issue_yet", bus.iss_valid, 0);
    step();
    check("t1_iss_valid", bus.iss_valid, 1);
    check("t1_iss_tag", bus.iss_tag, 1);
    check("t1_count_zero", bus.rs_count, 0);
    step();
    check("t1_idle", bus.iss_valid, 0);

    // Pending operand woken by a later CDB write.
    dispatch(OP_SUB, 4'd3, 32'h0, 4'd0, 32'h11, 4'd2, 5'd4);
    step();
    check("t2_wait", bus.iss_valid, 0);
    exp_q.push_back(pack(OP_SUB, 32'hDEAD, 32'h11, 4'd2, 5'd4));
    cdb(4'd3, 32'hDEAD);
    step();
    bus.cdb_en = 1'b0;
    check("t2_not_ready_same_edge", bus.iss_valid, 0);
    step();
    check("t2_iss_valid", bus.iss_valid, 1);
    check("t2_iss_a", bus.iss_a, 32'hDEAD);
    wait_drain("t2_drain");

    // Dispatch-time CDB bypass.
    exp_q.push_back(pack(OP_AND, 32'd4, 32'd9, 4'd5, 5'd6));
    cdb(4'd6, 32'd9);
    dispatch(OP_AND, 4'd0, 32'd4, 4'd6, 32'd0, 4'd5, 5'd6);
    bus.cdb_en = 1'b0;
    step();
    check("t3_iss_valid", bus.iss_valid, 1);
    check("t3_iss_b", bus.iss_b, 32'd9);
    wait_drain("t3_drain");

    // Fill all slots, drop an extra dispatch, free one slot via CDB.
    for (int i = 0; i < 8; i++) begin
      dispatch(OP_OR, 4'(i + 1), 32'd0, 4'd0, 32'(i), 4'd9, 5'(i));
    end
    check("t4_full", bus.rs_full, 1);
    check("t4_count8", bus.rs_count, 8);
    dispatch(OP_XOR, 4'd0, 32'h77, 4'd0, 32'h88, 4'd13, 5'd13);
    check("t4_drop_count", bus.rs_count, 8);
    exp_q.push_back(pack(OP_OR, 32'h33, 32'd2, 4'd9, 5'd2));
    cdb(4'd3, 32'h33);
    step();
    bus.cdb_en = 1'b0;
    check("t4_still_full", bus.rs_full, 1);
    step();
    check("t4_slot2_issue", bus.iss_a, 32'h33);
    check("t4_not_full", bus.rs_full, 0);
    check("t4_count7", bus.rs_count, 7);
    begin
      int tag_list[7] = '{1, 2, 4, 5, 6, 7, 8};
      foreach (tag_list[k]) begin
        exp_q.push_back(pack(OP_OR, 32'h100 + 32'(tag_list[k]), 32'(tag_list[k] - 1),
                             4'd9, 5'(tag_list[k] - 1)));
        cdb(4'(tag_list[k]), 32'h100 + 32'(tag_list[k]));
        step();
      end
    end
    bus.cdb_en = 1'b0;
    wait_drain("t4_drain");
    check("t4_empty", bus.rs_count, 0);

    // Back-pressure: outputs held while the ALU stalls.
    bus.iss_ready = 1'b0;
    dispatch(OP_ADD, 4'd0, 32'd1, 4'd0, 32'd2, 4'd10, 5'd10);
    dispatch(OP_ADD, 4'd0, 32'd3, 4'd0, 32'd4, 4'd11, 5'd11);
    for (int c = 0; c < 3; c++) begin
      check("t5_hold_valid", bus.iss_valid, 1);
      check("t5_hold_pkt", pack(bus.iss_op, bus.iss_a, bus.iss_b, bus.iss_tag, bus.iss_name),
            pack(OP_ADD, 32'd1, 32'd2, 4'd10, 5'd10));
      check("t5_hold_count", bus.rs_count, 1);
      step();
    end
    exp_q.push_back(pack(OP_ADD, 32'd1, 32'd2, 4'd10, 5'd10));
    exp_q.push_back(pack(OP_ADD, 32'd3, 32'd4, 4'd11, 5'd11));
    bus.iss_ready = 1'b1;
    step();
    check("t5_second_loaded", bus.iss_tag, 11);
    step();
    check("t5_idle", bus.iss_valid, 0);
    wait_drain("t5_drain");

    // Back-to-back ready dispatches at full throughput.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pack(OP_SLL, 32'(i + 20), 32'(i + 30), 4'(i + 1), 5'(i + 20)));
      dispatch(OP_SLL, 4'd0, 32'(i + 20), 4'd0, 32'(i + 30), 4'(i + 1), 5'(i + 20));
    end
    step();
    check("t6_count_zero", bus.rs_count, 0);
    wait_drain("t6_drain");

`ifdef RS_FLUSH_EN
    // Flush discards everything; same-cycle dispatch and CDB are ignored.
    for (int i = 0; i < 4; i++) begin
      dispatch(OP_SRL, 4'(i + 1), 32'd0, 4'd0, 32'd0, 4'd7, 5'(i));
    end
    check("t7_count4", bus.rs_count, 4);
    flush = 1'b1;
    cdb(4'd1, 32'h55);
    dispatch(OP_SRL, 4'd0, 32'd1, 4'd0, 32'd1, 4'd7, 5'd9);
    flush = 1'b0;
    bus.cdb_en = 1'b0;
    check("t7_count0", bus.rs_count, 0);
    check("t7_full0", bus.rs_full, 0);
    check("t7_iss_valid0", bus.iss_valid, 0);
    step();
    check("t7_no_issue", bus.iss_valid, 0);
`endif

    // Asynchronous reset mid-operation.
    bus.iss_ready = 1'b0;
    dispatch(OP_XOR, 4'd0, 32'hA, 4'd0, 32'hB, 4'd12, 5'd12);
    dispatch(OP_XOR, 4'd5, 32'h0, 4'd0, 32'hC, 4'd13, 5'd13);
    check("t8_pre_valid", bus.iss_valid, 1);
    check("t8_pre_count", bus.rs_count, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t8_async_valid", bus.iss_valid, 0);
    check("t8_async_count", bus.rs_count, 0);
    check("t8_async_a", bus.iss_a, 0);
    step();
    rst = 1'b0;
    bus.iss_ready = 1'b1;
    cdb(4'd5, 32'h99);
    step();
    bus.cdb_en = 1'b0;
    step();
    check("t8_post_idle", bus.iss_valid, 0);
    check("t8_post_count", bus.rs_count, 0);
    check("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
